// File: rtl/vending_fsm_multi_if.sv
// Coin-acceptor / dispenser bus for vending_fsm_multi.
// The master drives coins and customer/operator requests; the slave is the FSM.
interface vending_fsm_multi_if #(
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned STOCK_W  = 4
);
  logic                coin_valid;
  logic [1:0]          coin_val;
  logic                cancel;
  logic                restock;
  logic                vend;
  logic                change_valid;
  logic [1:0]          change_coin;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic [STOCK_W-1:0]  stock;
  logic                sold_out;
  logic                busy;

  modport master (
    output coin_valid, coin_val, cancel, restock,
    input  vend, change_valid, change_coin, coin_reject, credit, stock, sold_out, busy
  );

  modport slave (
    input  coin_valid, coin_val, cancel, restock,
    output vend, change_valid, change_coin, coin_reject, credit, stock, sold_out, busy
  );
endinterface

// File: rtl/vending_fsm_multi.sv
// Multi-coin vending FSM: accumulates 5/10/20 credit, vends at PRICE and pays change or
// refunds one coin per cycle, largest first. Every output is registered.
module vending_fsm_multi #(
  parameter int unsigned PRICE      = 15,
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  vending_fsm_multi_if.slave         vend_bus
);

  if (PRICE == 0 || (PRICE % 5) != 0) begin : g_price_chk
    $error("PRICE must be a non-zero multiple of 5");
  end
  if ((64'd1 << CREDIT_W) <= 64'(PRICE + 15)) begin : g_credit_chk
    $error("CREDIT_W too narrow for PRICE + 15");
  end
  if ((64'd1 << STOCK_W) <= 64'(STOCK_INIT)) begin : g_stock_chk
    $error("STOCK_INIT does not fit in STOCK_W bits");
  end

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] TEN_C   = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(5);

  typedef enum logic [2:0] {StIdle, StCollect, StVend, StChange, StRefund} state_e;

  state_e              r_state, w_state_d;
  logic [CREDIT_W-1:0] r_credit, w_credit_d;
  logic [STOCK_W-1:0]  r_stock, w_stock_d;
  logic                r_vend, r_change_valid, r_coin_reject, r_sold_out, r_busy;
  logic [1:0]          r_change_coin;

  logic                w_coin_present, w_accept, w_pay_d;
  logic [CREDIT_W-1:0] w_coin_amt, w_change_amt;

  always_comb begin
    w_state_d      = r_state;
    w_credit_d     = r_credit;
    w_stock_d      = r_stock;
    w_coin_present = vend_bus.coin_valid && (vend_bus.coin_val != 2'b00);
    w_accept       = w_coin_present && !r_sold_out && !vend_bus.cancel &&
                     ((r_state == StIdle) || (r_state == StCollect));
    w_change_amt   = (r_credit >= TEN_C) ? TEN_C : FIVE_C;

    case (vend_bus.coin_val)
      2'b01:   w_coin_amt = FIVE_C;
      2'b10:   w_coin_amt = TEN_C;
      2'b11:   w_coin_amt = CREDIT_W'(20);
      default: w_coin_amt = '0;
    endcase

    unique case (r_state)
      StIdle, StCollect: begin
        if (r_state == StCollect && vend_bus.cancel) begin
          w_state_d = StRefund;
        end else if (w_accept) begin
          w_credit_d = r_credit + w_coin_amt;
          w_state_d  = (w_credit_d >= PRICE_C) ? StVend : StCollect;
        end
        if (r_state == StIdle && vend_bus.restock) begin
          w_stock_d = STOCK_W'(STOCK_INIT);
        end
      end
      StVend: begin
        w_credit_d = r_credit - PRICE_C;
        if (r_stock != '0) w_stock_d = r_stock - STOCK_W'(1);
        w_state_d  = (w_credit_d != '0) ? StChange : StIdle;
      end
      StChange, StRefund: begin
        w_credit_d = r_credit - w_change_amt;
        if (w_credit_d == '0) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    w_pay_d = (w_state_d == StChange) || (w_state_d == StRefund);
  end

  // Outputs are decoded from next-state values so they line up with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_credit       <= '0;
      r_stock        <= STOCK_W'(STOCK_INIT);
      r_vend         <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_coin  <= 2'b00;
      r_coin_reject  <= 1'b0;
      r_sold_out     <= (STOCK_INIT == 0);
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_credit       <= w_credit_d;
      r_stock        <= w_stock_d;
      r_vend         <= (w_state_d == StVend);
      r_change_valid <= w_pay_d;
      r_change_coin  <= !w_pay_d ? 2'b00 : ((w_credit_d >= TEN_C) ? 2'b10 : 2'b01);
      r_coin_reject  <= w_coin_present && !w_accept;
      r_sold_out     <= (w_stock_d == '0);
      r_busy         <= (w_state_d == StVend) || w_pay_d;
    end
  end

  assign vend_bus.vend         = r_vend;
  assign vend_bus.change_valid = r_change_valid;
  assign vend_bus.change_coin  = r_change_coin;
  assign vend_bus.coin_reject  = r_coin_reject;
  assign vend_bus.credit       = r_credit;
  assign vend_bus.stock        = r_stock;
  assign vend_bus.sold_out     = r_sold_out;
  assign vend_bus.busy         = r_busy;

endmodule

// File: tb/tb_vending_fsm_multi.sv
// Bench for vending_fsm_multi: scenario tasks plus an event scoreboard on the default DUT;
// a second DUT with a single item in stock covers sold-out and restock.
module tb_vending_fsm_multi;

  localparam int EV_VEND = 1;
  localparam int EV_C5   = 2;
  localparam int EV_C10  = 3;
  localparam int EV_REJ  = 4;
  localparam int EV_BAD  = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_q[$];
  int   obs_q[$];
  int   exp_ev;

  vending_fsm_multi_if #(.CREDIT_W(8), .STOCK_W(4)) bus_a ();
  vending_fsm_multi_if #(.CREDIT_W(8), .STOCK_W(4)) bus_b ();

  vending_fsm_multi #(.PRICE(15), .CREDIT_W(8), .STOCK_W(4), .STOCK_INIT(10)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .vend_bus (bus_a)
  );

  vending_fsm_multi #(.PRICE(15), .CREDIT_W(8), .STOCK_W(4), .STOCK_INIT(1)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .vend_bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every vend / reject / change coin seen on dut_a must match the next expected.
  always @(negedge clk) begin
    obs_q.delete();
    if (bus_a.vend) obs_q.push_back(EV_VEND);
    if (bus_a.coin_reject) obs_q.push_back(EV_REJ);
    if (bus_a.change_valid) begin
      if (bus_a.change_coin == 2'b10) obs_q.push_back(EV_C10);
      else if (bus_a.change_coin == 2'b01) obs_q.push_back(EV_C5);
      else obs_q.push_back(EV_BAD);
    end
    foreach (obs_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: observed event %0d, expected no event", obs_q[i]);
      end else begin
        exp_ev = exp_q.pop_front();
        if (obs_q[i] !== exp_ev) begin
          n_fail++;
          $display("FAIL sb_event: observed event %0d, expected %0d", obs_q[i], exp_ev);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.coin_valid = 1'b0; bus_a.coin_val = 2'b00; bus_a.cancel = 1'b0; bus_a.restock = 1'b0;
    bus_b.coin_valid = 1'b0; bus_b.coin_val = 2'b00; bus_b.cancel = 1'b0; bus_b.restock = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_drained(input string name);
    repeat (2) tick();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_drained: %0d expected events never seen, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    n_checks++;
    if ({bus_a.vend, bus_a.change_valid, bus_a.change_coin, bus_a.coin_reject, bus_a.busy,
         bus_a.sold_out} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b want 0000000", {bus_a.vend, bus_a.change_valid,
               bus_a.change_coin, bus_a.coin_reject, bus_a.busy, bus_a.sold_out});
    end
    n_checks++;
    if (bus_a.credit !== 8'd0 || bus_a.stock !== 4'd10) begin
      n_fail++;
      $display("FAIL reset_regs: credit %0d stock %0d, want 0 and 10", bus_a.credit, bus_a.stock);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exact_price();
    apply_reset();
    bus_a.coin_valid = 1'b1; bus_a.coin_val = 2'b01;
    tick();
    n_checks++;
    if (bus_a.credit !== 8'd5 || bus_a.vend !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_collect: credit %0d vend %b, want 5 and 0", bus_a.credit, bus_a.vend);
    end
    bus_a.coin_val = 2'b10;
    exp_q.push_back(EV_VEND);
    tick();
    idle_inputs();
    n_checks++;
    if (bus_a.vend !== 1'b1 || bus_a.credit !== 8'd15 || bus_a.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_vend: vend %b credit %0d busy %b, want 1 15 1",
               bus_a.vend, bus_a.credit, bus_a.busy);
    end
    tick();
    n_checks++;
    if (bus_a.vend !== 1'b0 || bus_a.change_valid !== 1'b0 || bus_a.credit !== 8'd0 ||
        bus_a.stock !== 4'd9 || bus_a.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_after: vend %b chg %b credit %0d stock %0d busy %b, want 0 0 0 9 0",
               bus_a.vend, bus_a.change_valid, bus_a.credit, bus_a.stock, bus_a.busy);
    end
    check_drained("t1");
  endtask

  task automatic test_change();
    apply_reset();
    bus_a.coin_valid = 1'b1; bus_a.coin_val = 2'b11;
    exp_q.push_back(EV_VEND);
    exp_q.push_back(EV_C5);
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (bus_a.change_valid !== 1'b1 || bus_a.change_coin !== 2'b01 || bus_a.credit !== 8'd5 ||
        bus_a.stock !== 4'd9) begin
      n_fail++;
      $display("FAIL t2_change: valid %b coin %b credit %0d stock %0d, want 1 01 5 9",
               bus_a.change_valid, bus_a.change_coin, bus_a.credit, bus_a.stock);
    end
    tick();
    n_checks++;
    if (bus_a.credit !== 8'd0 || bus_a.change_valid !== 1'b0 || bus_a.change_coin !== 2'b00) begin
      n_fail++;
      $display("FAIL t2_done: credit %0d valid %b coin %b, want 0 0 00",
               bus_a.credit, bus_a.change_valid, bus_a.change_coin);
    end
    check_drained("t2");
  endtask

  task automatic test_cancel();
    apply_reset();
    bus_a.coin_valid = 1'b1; bus_a.coin_val = 2'b01;
    repeat (2) tick();
    bus_a.coin_valid = 1'b0; bus_a.cancel = 1'b1;
    exp_q.push_back(EV_C10);
    tick();
    idle_inputs();
    n_checks++;
    if (bus_a.change_coin !== 2'b10 || bus_a.vend !== 1'b0 || bus_a.credit !== 8'd10) begin
      n_fail++;
      $display("FAIL t3_refund: coin %b vend %b credit %0d, want 10 0 10",
               bus_a.change_coin, bus_a.vend, bus_a.credit);
    end
    tick();
    n_checks++;
    if (bus_a.credit !== 8'd0 || bus_a.stock !== 4'd10 || bus_a.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_done: credit %0d stock %0d busy %b, want 0 10 0",
               bus_a.credit, bus_a.stock, bus_a.busy);
    end
    check_drained("t3");
  endtask

  task automatic test_sold_out();
    apply_reset();
    bus_b.coin_valid = 1'b1; bus_b.coin_val = 2'b11;
    tick();
    idle_inputs();
    repeat (3) tick();
    n_checks++;
    if (bus_b.stock !== 4'd0 || bus_b.sold_out !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_sold: stock %0d sold_out %b, want 0 1", bus_b.stock, bus_b.sold_out);
    end
    bus_b.coin_valid = 1'b1; bus_b.coin_val = 2'b10;
    tick();
    idle_inputs();
    n_checks++;
    if (bus_b.coin_reject !== 1'b1 || bus_b.credit !== 8'd0) begin
      n_fail++;
      $display("FAIL t4_reject: reject %b credit %0d, want 1 0", bus_b.coin_reject, bus_b.credit);
    end
    tick();
    n_checks++;
    if (bus_b.coin_reject !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_reject_pulse: reject %b, want 0", bus_b.coin_reject);
    end
    bus_b.restock = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (bus_b.stock !== 4'd1 || bus_b.sold_out !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_restock: stock %0d sold_out %b, want 1 0", bus_b.stock, bus_b.sold_out);
    end
    bus_b.coin_valid = 1'b1; bus_b.coin_val = 2'b11;
    tick();
    idle_inputs();
    n_checks++;
    if (bus_b.vend !== 1'b1 || bus_b.credit !== 8'd20 || bus_b.coin_reject !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_accept: vend %b credit %0d reject %b, want 1 20 0",
               bus_b.vend, bus_b.credit, bus_b.coin_reject);
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus_a.coin_valid = 1'b1; bus_a.coin_val = 2'b11;
    exp_q.push_back(EV_VEND);
    exp_q.push_back(EV_C5);
    exp_q.push_back(EV_REJ);
    tick();
    idle_inputs();
    tick();
    bus_a.coin_valid = 1'b1; bus_a.coin_val = 2'b10;
    tick();
    idle_inputs();
    n_checks++;
    if (bus_a.coin_reject !== 1'b1 || bus_a.credit !== 8'd0 || bus_a.change_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_busy_reject: reject %b credit %0d chg %b, want 1 0 0",
               bus_a.coin_reject, bus_a.credit, bus_a.change_valid);
    end
    bus_a.coin_valid = 1'b1; bus_a.coin_val = 2'b01;
    tick();
    bus_a.cancel = 1'b1;
    exp_q.push_back(EV_REJ);
    exp_q.push_back(EV_C5);
    tick();
    idle_inputs();
    n_checks++;
    if (bus_a.coin_reject !== 1'b1 || bus_a.credit !== 8'd5 || bus_a.change_coin !== 2'b01) begin
      n_fail++;
      $display("FAIL t5_cancel_coin: reject %b credit %0d coin %b, want 1 5 01",
               bus_a.coin_reject, bus_a.credit, bus_a.change_coin);
    end
    tick();
    n_checks++;
    if (bus_a.credit !== 8'd0 || bus_a.stock !== 4'd9) begin
      n_fail++;
      $display("FAIL t5_done: credit %0d stock %0d, want 0 9", bus_a.credit, bus_a.stock);
    end
    check_drained("t5");
  endtask

  task automatic test_reset_mid_change();
    apply_reset();
    bus_a.coin_valid = 1'b1; bus_a.coin_val = 2'b10;
    tick();
    bus_a.coin_val = 2'b11;
    exp_q.push_back(EV_VEND);
    tick();
    idle_inputs();
    n_checks++;
    if (bus_a.credit !== 8'd30 || bus_a.vend !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_vend: credit %0d vend %b, want 30 1", bus_a.credit, bus_a.vend);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_a.change_valid !== 1'b0 || bus_a.change_coin !== 2'b00 || bus_a.credit !== 8'd0 ||
        bus_a.busy !== 1'b0 || bus_a.stock !== 4'd10) begin
      n_fail++;
      $display("FAIL t6_async: chg %b coin %b credit %0d busy %b stock %0d, want 0 00 0 0 10",
               bus_a.change_valid, bus_a.change_coin, bus_a.credit, bus_a.busy, bus_a.stock);
    end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (bus_a.credit !== 8'd0 || bus_a.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_after: credit %0d busy %b, want 0 0", bus_a.credit, bus_a.busy);
    end
    check_drained("t6");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_exact_price();
    test_change();
    test_cancel();
    test_sold_out();
    test_back_to_back();
    test_reset_mid_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
